// File: rtl/vga_bg_renderer.sv
// vga_bg_renderer: registered sky/grass background with grass scroll and
// a day/night fade FSM.
//
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   bright         - high in the active display area
//   hCount/vCount  - current scan position
//   mode_toggle    - single-cycle pulse requesting a day<->night change
//   scroll_en      - level; grass scrolls one pixel per SCROLL_DIV frames
//   rgb            - {R,G,B} colour of the previous cycle's position
//   night/busy     - registered FSM status flags
//
// Optional build macro: STARS_EN adds fixed stars to the night sky.
module vga_bg_renderer #(
    parameter int HORIZON     = 240,
    parameter int SCROLL_DIV  = 2,
    parameter int FADE_FRAMES = 8,
    parameter int MAX_DIM     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bright,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        mode_toggle,
    input  logic        scroll_en,
    output logic [11:0] rgb,
    output logic        night,
    output logic        busy
);

    typedef enum logic [1:0] {DAY, FADE_DN, NIGHT, FADE_UP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  dim_q, dim_d;
    logic [4:0]  scroll_off_q, scroll_off_d;
    logic [15:0] scroll_cnt_q, scroll_cnt_d;
    logic [15:0] fade_cnt_q, fade_cnt_d;
    logic [9:0]  prev_h_q, prev_v_q;
    logic [11:0] rgb_q, rgb_d;
    logic        night_q, night_d;
    logic        busy_q, busy_d;

    logic        tick;
    logic [9:0]  sx;
    logic        stripe;
    logic [3:0]  dim4;

    // One pulse per frame, even when the origin pixel is held many cycles.
    assign tick = (hCount == 10'd0) && (vCount == 10'd0) &&
                  !((prev_h_q == 10'd0) && (prev_v_q == 10'd0));

    assign sx     = hCount + {5'd0, scroll_off_q};
    assign stripe = sx[4] ^ vCount[3];
    assign dim4   = {1'b0, dim_q};

    always_comb begin
        rgb_d = 12'h000;
        if (bright) begin
            if (vCount < 10'(HORIZON)) begin
                rgb_d = {8'h00, 4'({1'b0, vCount[7:5]}) + 4'd4 - dim4};
`ifdef STARS_EN
                if (state_q == NIGHT &&
                    (hCount[5:0] ^ vCount[5:0]) == 6'h2A)
                    rgb_d = 12'hFFF;
`endif
            end else begin
                rgb_d = {4'h0, 4'd8 + (stripe ? 4'd4 : 4'd0) - dim4, 4'h1};
            end
        end
    end

    always_comb begin
        scroll_cnt_d = scroll_cnt_q;
        scroll_off_d = scroll_off_q;
        if (tick && scroll_en) begin
            if (scroll_cnt_q == 16'(SCROLL_DIV - 1)) begin
                scroll_cnt_d = 16'd0;
                scroll_off_d = scroll_off_q + 5'd1;
            end else begin
                scroll_cnt_d = scroll_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        dim_d      = dim_q;
        fade_cnt_d = fade_cnt_q;
        unique case (state_q)
            DAY: begin
                if (mode_toggle) begin
                    state_d    = FADE_DN;
                    fade_cnt_d = 16'd0;
                end
            end
            FADE_DN: begin
                if (tick) begin
                    if (fade_cnt_q == 16'(FADE_FRAMES - 1)) begin
                        fade_cnt_d = 16'd0;
                        dim_d      = dim_q + 3'd1;
                        if (dim_d == 3'(MAX_DIM))
                            state_d = NIGHT;
                    end else begin
                        fade_cnt_d = fade_cnt_q + 16'd1;
                    end
                end
            end
            NIGHT: begin
                if (mode_toggle) begin
                    state_d    = FADE_UP;
                    fade_cnt_d = 16'd0;
                end
            end
            FADE_UP: begin
                if (tick) begin
                    if (fade_cnt_q == 16'(FADE_FRAMES - 1)) begin
                        fade_cnt_d = 16'd0;
                        dim_d      = dim_q - 3'd1;
                        if (dim_d == 3'd0)
                            state_d = DAY;
                    end else begin
                        fade_cnt_d = fade_cnt_q + 16'd1;
                    end
                end
            end
        endcase
        night_d = (state_d == NIGHT);
        busy_d  = (state_d == FADE_DN) || (state_d == FADE_UP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= DAY;
            dim_q        <= 3'd0;
            scroll_off_q <= 5'd0;
            scroll_cnt_q <= 16'd0;
            fade_cnt_q   <= 16'd0;
            prev_h_q     <= 10'd0;
            prev_v_q     <= 10'd0;
            rgb_q        <= 12'h000;
            night_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dim_q        <= dim_d;
            scroll_off_q <= scroll_off_d;
            scroll_cnt_q <= scroll_cnt_d;
            fade_cnt_q   <= fade_cnt_d;
            prev_h_q     <= hCount;
            prev_v_q     <= vCount;
            rgb_q        <= rgb_d;
            night_q      <= night_d;
            busy_q       <= busy_d;
        end
    end

    assign rgb   = rgb_q;
    assign night = night_q;
    assign busy  = busy_q;

endmodule
